// File: rtl/mul_arb_pkg.sv
// Shared types and widths for the multiplier arbiter and its round-robin picker.
package mul_arb_pkg;

    localparam int OPND_W = 32;
    localparam int PROD_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx
);

    always_comb begin
        logic          found;
        logic [PW-1:0] cand;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = PW'((int'(ptr) + i) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/multiplier_arbiter.sv
// Time-shares one iterative multiplier among NUM_REQ clients: pick, launch, wait
// (with timeout), then hold the product on a shared response bus until consumed.
module multiplier_arbiter
    import mul_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*OPND_W-1:0] req_a,
    input  logic [NUM_REQ*OPND_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        resp_valid,
    input  logic [NUM_REQ-1:0]        resp_ready,
    output logic [PROD_W-1:0]         resp_r,
    output logic                      resp_err,
    output logic                      mul_valid_in,
    output logic [OPND_W-1:0]         mul_a,
    output logic [OPND_W-1:0]         mul_b,
    input  logic                      mul_valid_out,
    input  logic [PROD_W-1:0]         mul_r
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t          state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    gnt_q, gnt_d;
    logic [OPND_W-1:0]   a_q, a_d, b_q, b_d;
    logic [PROD_W-1:0]   r_q, r_d;
    logic                err_q, err_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;

    logic [NUM_REQ-1:0]  arb_grant;
    logic [PTR_W-1:0]    arb_idx;
    logic [OPND_W-1:0]   opnd_a [NUM_REQ];
    logic [OPND_W-1:0]   opnd_b [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_opnd
        assign opnd_a[i] = req_a[OPND_W*i +: OPND_W];
        assign opnd_b[i] = req_b[OPND_W*i +: OPND_W];
    end

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    // Operands stay on the multiplier inputs for the whole operation.
    assign mul_a = a_q;
    assign mul_b = b_q;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        a_d          = a_q;
        b_d          = b_q;
        r_d          = r_q;
        err_d        = err_q;
        tmr_d        = tmr_q;
        req_ready    = '0;
        resp_valid   = '0;
        resp_r       = '0;
        resp_err     = 1'b0;
        mul_valid_in = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready = arb_grant;
                    gnt_d     = arb_idx;
                    a_d       = opnd_a[arb_idx];
                    b_d       = opnd_b[arb_idx];
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                mul_valid_in = 1'b1;
                tmr_d        = '0;
                state_d      = WAIT;
            end
            WAIT: begin
                // Completion is checked first so it beats a same-cycle timeout.
                if (mul_valid_out) begin
                    r_d     = mul_r;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    r_d     = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            RESP: begin
                resp_valid[gnt_q] = 1'b1;
                resp_r            = r_q;
                resp_err          = err_q;
                if (resp_ready[gnt_q]) begin
                    ptr_d   = (gnt_q == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_q + PTR_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            err_q   <= 1'b0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            err_q   <= err_d;
            tmr_q   <= tmr_d;
        end
    end

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Bench for multiplier_arbiter with a latency-programmable multiplier model and
// a round-robin/product reference model.
module tb_multiplier_arbiter;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid, req_ready, resp_valid, resp_ready;
    logic [N*32-1:0]   req_a, req_b;
    logic [63:0]       resp_r;
    logic              resp_err;
    logic              mul_valid_in;
    logic [31:0]       mul_a, mul_b;
    logic              mul_valid_out;
    logic [63:0]       mul_r;

    int checks = 0;
    int failures = 0;
    int mptr = 0;

    always #5 clk = ~clk;

    multiplier_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_r        (resp_r),
        .resp_err      (resp_err),
        .mul_valid_in  (mul_valid_in),
        .mul_a         (mul_a),
        .mul_b         (mul_b),
        .mul_valid_out (mul_valid_out),
        .mul_r         (mul_r)
    );

    // Multiplier model: done becomes visible 'lat' cycles after the start cycle,
    // stays high afterwards; product is junk while busy. stub=1 never completes.
    int  lat = 3;
    bit  stub = 1'b0;
    int  mcnt;
    bit  mbusy;
    wire [63:0] mul_prod = {32'd0, mul_a} * {32'd0, mul_b};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_valid_out <= 1'b0;
            mul_r         <= '0;
            mbusy         <= 1'b0;
            mcnt          <= 0;
        end else if (mul_valid_in) begin
            if (stub) begin
                mul_valid_out <= 1'b0;
                mul_r         <= {$urandom, $urandom};
                mbusy         <= 1'b0;
            end else if (lat <= 1) begin
                mul_valid_out <= 1'b1;
                mul_r         <= mul_prod;
                mbusy         <= 1'b0;
            end else begin
                mul_valid_out <= 1'b0;
                mul_r         <= {$urandom, $urandom};
                mbusy         <= 1'b1;
                mcnt          <= lat - 1;
            end
        end else if (mbusy) begin
            if (mcnt == 1) begin
                mul_valid_out <= 1'b1;
                mul_r         <= mul_prod;
                mbusy         <= 1'b0;
            end
            mcnt <= mcnt - 1;
        end
    end

    // Observer of grants and start pulses.
    int           gnt_cnt = 0;
    int           pulse_cnt = 0;
    logic [N-1:0] gnt_vec = '0;

    always @(negedge clk) begin
        if (req_ready != '0) begin
            gnt_cnt <= gnt_cnt + 1;
            gnt_vec <= req_ready;
        end
        if (mul_valid_in) pulse_cnt <= pulse_cnt + 1;
    end

    function automatic int rr_pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++)
            if (m[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] bit_of(input int i);
        logic [N-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int prev, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (gnt_cnt != prev) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_resp(output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            cyc++;
            if (resp_valid != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic ack(input int g);
        tick();
        resp_ready = bit_of(g);
        tick();
        resp_ready = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        mptr  = 0;
    endtask

    // One request from client r; returns what was observed, checks nothing.
    task automatic run_op(input int r, input logic [31:0] a, input logic [31:0] b,
                          output bit gok, output bit rok, output int cyc, output int np);
        int prev, p0;
        prev = gnt_cnt;
        p0   = pulse_cnt;
        req_a[32*r +: 32] = a;
        req_b[32*r +: 32] = b;
        req_valid[r] = 1'b1;
        wait_grant(prev, gok);
        tick();
        req_valid[r] = 1'b0;
        req_a[32*r +: 32] = $urandom;
        req_b[32*r +: 32] = $urandom;
        wait_resp(rok, cyc);
        np = pulse_cnt - p0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if ({req_ready, resp_valid, resp_err, mul_valid_in} !== '0) begin failures++; $display("FAIL reset_ctrl got=%b exp=0", {req_ready, resp_valid, resp_err, mul_valid_in}); end
        checks++; if ({resp_r, mul_a, mul_b} !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", {resp_r, mul_a, mul_b}); end
        rst_n = 1'b1;
        mptr  = 0;
        tick();
    endtask

    task automatic test_single();
        bit gok, rok; int cyc, np;
        lat = 3;
        run_op(0, 32'd3, 32'd5, gok, rok, cyc, np);
        checks++; if (!gok || gnt_vec !== 4'b0001) begin failures++; $display("FAIL single_grant got=%b exp=0001", gnt_vec); end
        checks++; if (!rok || resp_valid !== 4'b0001) begin failures++; $display("FAIL single_rv got=%b exp=0001", resp_valid); end
        checks++; if (resp_r !== 64'd15 || resp_err !== 1'b0) begin failures++; $display("FAIL single_r got=%0d err=%b exp=15 err=0", resp_r, resp_err); end
        checks++; if (np !== 1) begin failures++; $display("FAIL single_pulses got=%0d exp=1", np); end
        checks++; if (cyc !== lat + 2) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", cyc, lat + 2); end
        ack(0);
        mptr = 1;
        checks++; if (resp_valid !== '0) begin failures++; $display("FAIL single_rv_clear got=%b exp=0", resp_valid); end
    endtask

    task automatic test_max();
        bit gok, rok; int cyc, np;
        lat = 1;
        run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, gok, rok, cyc, np);
        checks++; if (!rok || resp_valid !== 4'b0010) begin failures++; $display("FAIL max_rv got=%b exp=0010", resp_valid); end
        checks++; if (resp_r !== 64'hFFFF_FFFE_0000_0001 || resp_err !== 1'b0) begin failures++; $display("FAIL max_r got=%h err=%b exp=fffffffe00000001 err=0", resp_r, resp_err); end
        checks++; if (cyc !== 3) begin failures++; $display("FAIL max_latency got=%0d exp=3", cyc); end
        ack(1);
        mptr = 2;
    endtask

    task automatic test_rr_all();
        bit gok, rok; int cyc, prev, e;
        lat = 2;
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = 32'(i + 2);
            req_b[32*i +: 32] = 32'd7;
        end
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            e    = rr_pick('1, mptr);
            prev = gnt_cnt;
            wait_grant(prev, gok);
            checks++; if (!gok || gnt_vec !== bit_of(e)) begin failures++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, gnt_vec, bit_of(e)); end
            wait_resp(rok, cyc);
            checks++; if (!rok || resp_valid !== bit_of(e)) begin failures++; $display("FAIL rr_rv k=%0d got=%b exp=%b", k, resp_valid, bit_of(e)); end
            checks++; if (resp_r !== 64'((e + 2) * 7)) begin failures++; $display("FAIL rr_r k=%0d got=%0d exp=%0d", k, resp_r, (e + 2) * 7); end
            ack(e);
            req_valid = (k == 4) ? '0 : '1;
            mptr = (e + 1) % N;
        end
    endtask

    task automatic test_hold();
        bit gok, rok; int cyc, np, prev, p0;
        lat = 4;
        req_a[32*3 +: 32] = 32'd11;
        req_b[32*3 +: 32] = 32'd13;
        run_op(2, 32'd1234, 32'd5678, gok, rok, cyc, np);
        req_valid = 4'b1011;
        prev = gnt_cnt;
        p0   = pulse_cnt;
        checks++; if (!rok || resp_valid !== 4'b0100) begin failures++; $display("FAIL hold_rv0 got=%b exp=0100", resp_valid); end
        for (int k = 0; k < 10; k++) begin
            tick();
            resp_ready = 4'b1011;
            @(negedge clk);
            #1;
            checks++; if (resp_valid !== 4'b0100 || resp_r !== 64'd7006652) begin failures++; $display("FAIL hold_stable k=%0d rv=%b r=%0d exp rv=0100 r=7006652", k, resp_valid, resp_r); end
            checks++; if (gnt_cnt !== prev || pulse_cnt !== p0) begin failures++; $display("FAIL hold_quiet k=%0d grants=%0d pulses=%0d exp=0", k, gnt_cnt - prev, pulse_cnt - p0); end
        end
        resp_ready = '0;
        ack(2);
        mptr = 3;
        wait_grant(prev, gok);
        checks++; if (!gok || gnt_vec !== 4'b1000) begin failures++; $display("FAIL hold_next_grant got=%b exp=1000", gnt_vec); end
        tick();
        req_valid = '0;
        wait_resp(rok, cyc);
        checks++; if (!rok || resp_r !== 64'd143) begin failures++; $display("FAIL hold_next_r got=%0d exp=143", resp_r); end
        ack(3);
        mptr = 0;
    endtask

    task automatic test_timeout();
        bit gok, rok; int cyc, np;
        stub = 1'b1;
        run_op(mptr, 32'd9, 32'd9, gok, rok, cyc, np);
        checks++; if (!rok || resp_err !== 1'b1 || resp_r !== 64'd0) begin failures++; $display("FAIL tmo_stub err=%b r=%0d exp err=1 r=0", resp_err, resp_r); end
        checks++; if (cyc !== 18 || np !== 1) begin failures++; $display("FAIL tmo_stub_lat got=%0d pulses=%0d exp=18 pulses=1", cyc, np); end
        ack(mptr);
        mptr = (mptr + 1) % N;
        stub = 1'b0;
        lat  = 16;
        run_op(mptr, 32'd100, 32'd3, gok, rok, cyc, np);
        checks++; if (!rok || resp_err !== 1'b0 || resp_r !== 64'd300 || cyc !== 18) begin failures++; $display("FAIL tmo_edge16 err=%b r=%0d cyc=%0d exp err=0 r=300 cyc=18", resp_err, resp_r, cyc); end
        ack(mptr);
        mptr = (mptr + 1) % N;
        lat  = 17;
        run_op(mptr, 32'd100, 32'd3, gok, rok, cyc, np);
        checks++; if (!rok || resp_err !== 1'b1 || resp_r !== 64'd0 || cyc !== 18) begin failures++; $display("FAIL tmo_edge17 err=%b r=%0d cyc=%0d exp err=1 r=0 cyc=18", resp_err, resp_r, cyc); end
        ack(mptr);
        mptr = (mptr + 1) % N;
        lat  = 3;
    endtask

    task automatic test_reset_mid();
        bit gok, rok; int cyc, np, prev, p0;
        lat  = 8;
        prev = gnt_cnt;
        req_a[32*mptr +: 32] = 32'd77;
        req_b[32*mptr +: 32] = 32'd88;
        req_valid = bit_of(mptr);
        wait_grant(prev, gok);
        tick();
        req_valid = '0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({req_ready, resp_valid, resp_err, mul_valid_in} !== '0 || {resp_r, mul_a, mul_b} !== '0) begin failures++; $display("FAIL midrst_outputs ctrl=%b data=%h exp=0", {req_ready, resp_valid, resp_err, mul_valid_in}, {resp_r, mul_a, mul_b}); end
        tick();
        tick();
        rst_n = 1'b1;
        mptr  = 0;
        p0    = pulse_cnt;
        rok   = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (resp_valid != '0) rok = 1'b1;
        end
        checks++; if (rok || pulse_cnt !== p0) begin failures++; $display("FAIL midrst_abandon resp_seen=%b pulses=%0d exp=0", rok, pulse_cnt - p0); end
        lat = 5;
        run_op(0, 32'd6, 32'd7, gok, rok, cyc, np);
        checks++; if (!gok || gnt_vec !== 4'b0001) begin failures++; $display("FAIL midrst_grant got=%b exp=0001", gnt_vec); end
        checks++; if (!rok || resp_r !== 64'd42 || resp_err !== 1'b0) begin failures++; $display("FAIL midrst_r got=%0d err=%b exp=42 err=0", resp_r, resp_err); end
        ack(0);
        mptr = 1;
    endtask

    task automatic test_random();
        logic [N-1:0]  pend;
        logic [31:0]   opa [N];
        logic [31:0]   opb [N];
        logic [63:0]   exp_r;
        bit gok, rok; int cyc, prev, p0, e;
        pend = '0;
        for (int it = 0; it < 40; it++) begin
            for (int r = 0; r < N; r++) begin
                if (!pend[r] && ($urandom_range(0, 1) == 1)) begin
                    pend[r] = 1'b1;
                    case ($urandom_range(0, 5))
                        0:       opa[r] = 32'd0;
                        1:       opa[r] = 32'hFFFF_FFFF;
                        default: opa[r] = $urandom;
                    endcase
                    opb[r] = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
                    req_a[32*r +: 32] = opa[r];
                    req_b[32*r +: 32] = opb[r];
                end
            end
            if (pend == '0) begin
                pend[0] = 1'b1;
                opa[0] = $urandom;
                opb[0] = $urandom;
                req_a[31:0] = opa[0];
                req_b[31:0] = opb[0];
            end
            lat  = $urandom_range(1, 12);
            e    = rr_pick(pend, mptr);
            prev = gnt_cnt;
            p0   = pulse_cnt;
            req_valid = pend;
            wait_grant(prev, gok);
            checks++; if (!gok || gnt_vec !== bit_of(e)) begin failures++; $display("FAIL rnd_grant it=%0d got=%b exp=%b", it, gnt_vec, bit_of(e)); end
            tick();
            pend[e] = 1'b0;
            for (int r = 0; r < N; r++)
                if (pend[r] && ($urandom_range(0, 7) == 0)) pend[r] = 1'b0;
            req_valid = pend;
            req_a[32*e +: 32] = $urandom;
            req_b[32*e +: 32] = $urandom;
            exp_r = 64'(opa[e]) * 64'(opb[e]);
            wait_resp(rok, cyc);
            checks++; if (!rok || resp_valid !== bit_of(e)) begin failures++; $display("FAIL rnd_rv it=%0d got=%b exp=%b", it, resp_valid, bit_of(e)); end
            checks++; if (resp_r !== exp_r || resp_err !== 1'b0) begin failures++; $display("FAIL rnd_r it=%0d got=%h err=%b exp=%h err=0", it, resp_r, resp_err, exp_r); end
            checks++; if (pulse_cnt - p0 !== 1) begin failures++; $display("FAIL rnd_pulses it=%0d got=%0d exp=1", it, pulse_cnt - p0); end
            checks++; if (cyc !== lat + 2) begin failures++; $display("FAIL rnd_latency it=%0d got=%0d exp=%0d", it, cyc, lat + 2); end
            repeat ($urandom_range(0, 3)) tick();
            ack(e);
            mptr = (e + 1) % N;
        end
        req_valid = '0;
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0;
        resp_ready = '0;
        req_a      = '0;
        req_b      = '0;
        test_reset();
        test_single();
        test_max();
        test_rr_all();
        test_hold();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
